// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one synchronous RAM port among NUM_CH requesters.
// Round-robin grant, one transaction in flight, fixed RAM read latency.
// Optional macro RAM_ARB_LOCK_EN adds the chLock port, which keeps the grant
// on one channel across transactions (atomic read-modify-write).
//
// state | meaning
// IDLE  | no transaction; arbitrate among eligible channels
// ISSUE | RAM strobe driven for one cycle, granted channel busy
// WAIT  | read in flight, counting down the RAM latency
// DONE  | granted channel sees done for one cycle, read data valid
module ram_port_arbiter #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*ADDR_W-1:0] chRamAddress,
  input  logic [NUM_CH*DATA_W-1:0] chRamWrite,
  input  logic [NUM_CH-1:0]        chReadReq,
  input  logic [NUM_CH-1:0]        chWriteReq,
`ifdef RAM_ARB_LOCK_EN
  input  logic [NUM_CH-1:0]        chLock,
`endif
  output logic [2*NUM_CH-1:0]      chStatus,
  output logic [DATA_W-1:0]        chRamRead,
  output logic [ADDR_W-1:0]        phRamAddress,
  output logic [DATA_W-1:0]        phRamWrite,
  output logic                     phReadReq,
  output logic                     phWriteReq,
  input  logic [DATA_W-1:0]        phRamRead
);

  localparam int PTR_W = $clog2(NUM_CH);
  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} stateT;

  stateT            state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] g;
  logic [CNT_W-1:0] waitCnt;
  logic [NUM_CH-1:0] armed;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] elig;
  logic             grantValid;
  logic [PTR_W-1:0] pick;
  logic [PTR_W-1:0] rrSel;
  int               rrIdx;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWdata;
  logic             selWr;
`ifdef RAM_ARB_LOCK_EN
  logic             lockActive;
`endif

  assign req  = chReadReq | chWriteReq;
  assign elig = armed & req;

  // Round-robin search from ptr+1; a held lock overrides it with the locked channel.
  always_comb begin
    grantValid = 1'b0;
    pick       = '0;
    rrIdx      = 0;
    rrSel      = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      rrIdx = int'(ptr) + k;
      if (rrIdx >= NUM_CH) rrIdx = rrIdx - NUM_CH;
      rrSel = PTR_W'(rrIdx);
      if (!grantValid && elig[rrSel]) begin
        grantValid = 1'b1;
        pick       = rrSel;
      end
    end
`ifdef RAM_ARB_LOCK_EN
    if (lockActive && chLock[g]) begin
      grantValid = elig[g];
      pick       = g;
    end
`endif
  end

  // Request fields of the channel about to be granted; write wins over read.
  always_comb begin
    selAddr  = chRamAddress[pick*ADDR_W +: ADDR_W];
    selWdata = chRamWrite[pick*DATA_W +: DATA_W];
    selWr    = chWriteReq[pick];
  end

  // Arbitration FSM with registered RAM strobes, status and read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      ptr          <= PTR_W'(NUM_CH - 1);
      g            <= '0;
      waitCnt      <= '0;
      armed        <= '1;
      chStatus     <= '0;
      chRamRead    <= '0;
      phRamAddress <= '0;
      phRamWrite   <= '0;
      phReadReq    <= 1'b0;
      phWriteReq   <= 1'b0;
`ifdef RAM_ARB_LOCK_EN
      lockActive   <= 1'b0;
`endif
    end else begin
      // armed drops when a channel's done cycle ends, and comes back once its
      // request is seen low, so a requester slow to drop is not served twice.
      for (int i = 0; i < NUM_CH; i++) begin
        if (state == DONE && g == PTR_W'(i)) armed[i] <= 1'b0;
        else if (!req[i])                    armed[i] <= 1'b1;
      end

      case (state)
        IDLE: begin
`ifdef RAM_ARB_LOCK_EN
          if (lockActive && !chLock[g]) lockActive <= 1'b0;
`endif
          if (grantValid) begin
            g            <= pick;
            ptr          <= pick;
            phRamAddress <= selAddr;
            phRamWrite   <= selWdata;
            phWriteReq   <= selWr;
            phReadReq    <= !selWr;
            chStatus[pick*2 +: 2] <= 2'b01;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          phReadReq  <= 1'b0;
          phWriteReq <= 1'b0;
          // phWriteReq still holds this transaction's op during ISSUE.
          if (phWriteReq) begin
            chStatus[g*2 +: 2] <= 2'b10;
            state              <= DONE;
          end else begin
            waitCnt <= CNT_W'(RD_LATENCY - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (waitCnt == '0) begin
            chRamRead          <= phRamRead;
            chStatus[g*2 +: 2] <= 2'b10;
            state              <= DONE;
          end else begin
            waitCnt <= waitCnt - 1'b1;
          end
        end
        DONE: begin
          chStatus <= '0;
`ifdef RAM_ARB_LOCK_EN
          lockActive <= chLock[g];
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: NUM_CH=3, RD_LATENCY=2, with a
// behavioural RAM. Stimulus pushes expected strobes and done events; a
// negedge monitor pops and compares whenever the DUT presents one.
module tb_ram_port_arbiter;
  localparam int NUM_CH = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset;
  logic [NUM_CH*AW-1:0] chRamAddress;
  logic [NUM_CH*DW-1:0] chRamWrite;
  logic [NUM_CH-1:0]    chReadReq;
  logic [NUM_CH-1:0]    chWriteReq;
`ifdef RAM_ARB_LOCK_EN
  logic [NUM_CH-1:0]    chLock;
`endif
  logic [2*NUM_CH-1:0]  chStatus;
  logic [DW-1:0]        chRamRead;
  logic [AW-1:0]        phRamAddress;
  logic [DW-1:0]        phRamWrite;
  logic                 phReadReq;
  logic                 phWriteReq;
  logic [DW-1:0]        phRamRead;

  ram_port_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .chRamAddress(chRamAddress), .chRamWrite(chRamWrite),
    .chReadReq(chReadReq), .chWriteReq(chWriteReq),
`ifdef RAM_ARB_LOCK_EN
    .chLock(chLock),
`endif
    .chStatus(chStatus), .chRamRead(chRamRead),
    .phRamAddress(phRamAddress), .phRamWrite(phRamWrite),
    .phReadReq(phReadReq), .phWriteReq(phWriteReq), .phRamRead(phRamRead)
  );

  always #5 clk = ~clk;

  typedef struct { logic isWr; logic [31:0] addr; logic [31:0] data; } strobeT;
  typedef struct { int ch; logic isRd; logic [31:0] data; } doneT;

  strobeT expStrobe[$];
  doneT   expDone[$];
  int vectors = 0;
  int miscompares = 0;
  int strobeCount = 0;
  int doneCount = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [1:0] st(int ch);
    return chStatus[ch*2 +: 2];
  endfunction

  // Behavioural RAM: writes land at the strobe edge, reads appear LAT cycles later.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rdStage;
  always @(posedge clk) begin
    if (phWriteReq) mem[phRamAddress] = phRamWrite;
    if (phReadReq) rdStage <= mem.exists(phRamAddress) ? mem[phRamAddress] : 32'h0;
    phRamRead <= rdStage;
  end

  // Monitor: pops expectations whenever a strobe or a done status appears.
  strobeT monS;
  doneT   monD;
  always @(negedge clk) begin
    if (reset) begin
      if (phReadReq || phWriteReq) begin
        strobeCount++;
        if (expStrobe.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL strobe: unexpected rd=%b wr=%b addr %h, none expected", phReadReq, phWriteReq, phRamAddress);
        end else begin
          monS = expStrobe.pop_front();
          check("strobe kind {wr,rd}", 32'({phWriteReq, phReadReq}), monS.isWr ? 32'd2 : 32'd1);
          check("strobe addr", phRamAddress, monS.addr);
          if (monS.isWr) check("strobe wdata", phRamWrite, monS.data);
        end
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (chStatus[c*2 +: 2] == 2'b10) begin
          doneCount++;
          if (expDone.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL done: unexpected done on ch%0d, none expected", c);
          end else begin
            monD = expDone.pop_front();
            check("done channel", 32'(c), 32'(monD.ch));
            if (monD.isRd) check("done read data", chRamRead, monD.data);
          end
        end
      end
    end
  end

  task automatic drive(input int ch, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] data);
    chReadReq[ch] = rd;
    chWriteReq[ch] = wr;
    chRamAddress[ch*AW +: AW] = addr;
    chRamWrite[ch*DW +: DW] = data;
  endtask

  task automatic expectTxn(input int ch, input logic isWr, input logic [31:0] addr,
                           input logic [31:0] data);
    expStrobe.push_back('{isWr, addr, isWr ? data : 32'h0});
    expDone.push_back('{ch, !isWr, data});
  endtask

  // Counts negedges until ch shows done; n=1 is the cycle before the sampling edge.
  task automatic waitDone(input int ch, input int expN, input string name);
    int n;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (st(ch) == 2'b10) begin
        n = k;
        break;
      end
    end
    check(name, 32'(n), 32'(expN));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin
    int sc;
    mem[32'h100] = 32'hDEADBEEF;
    mem[32'h200] = 32'h12345678;
    mem[32'h204] = 32'h0CAFE0F0;
    mem[32'h300] = 32'hA5A55A5A;
    rdStage = '0;
    reset = 1'b0;
    chRamAddress = '0; chRamWrite = '0; chReadReq = '0; chWriteReq = '0;
`ifdef RAM_ARB_LOCK_EN
    chLock = '0;
`endif
    repeat (2) @(negedge clk);
    check("reset chStatus", 32'(chStatus), 32'h0);
    check("reset phReadReq", 32'(phReadReq), 32'h0);
    check("reset phWriteReq", 32'(phWriteReq), 32'h0);
    check("reset phRamAddress", phRamAddress, 32'h0);
    check("reset chRamRead", chRamRead, 32'h0);
    tick(1);
    reset = 1'b1;
    tick(2);

    // Single read on ch0: done 3 cycles after the sampling edge.
    expectTxn(0, 1'b0, 32'h100, 32'hDEADBEEF);
    drive(0, 1'b1, 1'b0, 32'h100, 32'h0);
    waitDone(0, LAT + 3, "single read latency");
    tick(1);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick(3);

    // Contention after reset: ch0 before ch1.
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(1);
    expectTxn(0, 1'b1, 32'h10, 32'hA);
    expectTxn(1, 1'b1, 32'h20, 32'hB);
    drive(0, 1'b0, 1'b1, 32'h10, 32'hA);
    drive(1, 1'b0, 1'b1, 32'h20, 32'hB);
    waitDone(0, 3, "contention ch0 write latency");
    tick(1);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    waitDone(1, 3, "contention ch1 follows");
    tick(1);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    check("ram[0x10]", mem[32'h10], 32'hA);
    check("ram[0x20]", mem[32'h20], 32'hB);
    tick(3);

    // Held request: one read only until the request drops and re-asserts.
    sc = strobeCount;
    expectTxn(1, 1'b0, 32'h200, 32'h12345678);
    drive(1, 1'b1, 1'b0, 32'h200, 32'h0);
    waitDone(1, LAT + 3, "held read latency");
    tick(1);
    drive(1, 1'b1, 1'b0, 32'h204, 32'h0);
    tick(5);
    check("held request strobes", 32'(strobeCount - sc), 32'd1);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick(1);
    expectTxn(1, 1'b0, 32'h204, 32'h0CAFE0F0);
    drive(1, 1'b1, 1'b0, 32'h204, 32'h0);
    waitDone(1, LAT + 3, "re-asserted read latency");
    tick(1);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick(3);

    // Reset during WAIT: outputs clear at once, ch0 still wins first afterwards.
    expStrobe.push_back('{1'b0, 32'h300, 32'h0});
    drive(2, 1'b1, 1'b0, 32'h300, 32'h0);
    tick(3);
    check("ch2 busy in WAIT", 32'(st(2)), 32'h1);
    reset = 1'b0;
    #1;
    check("mid-read reset chStatus", 32'(chStatus), 32'h0);
    check("mid-read reset phReadReq", 32'(phReadReq), 32'h0);
    check("mid-read reset phWriteReq", 32'(phWriteReq), 32'h0);
    expectTxn(0, 1'b0, 32'h100, 32'hDEADBEEF);
    expectTxn(2, 1'b0, 32'h300, 32'hA5A55A5A);
    drive(0, 1'b1, 1'b0, 32'h100, 32'h0);
    tick(1);
    reset = 1'b1;
    waitDone(0, LAT + 3, "post-reset ch0 first");
    tick(1);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    waitDone(2, LAT + 3, "post-reset ch2 next");
    tick(1);
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    tick(3);

    // Read and write together on ch2: a single write, read data register untouched.
    expectTxn(2, 1'b1, 32'h40, 32'h55);
    drive(2, 1'b1, 1'b1, 32'h40, 32'h55);
    waitDone(2, 3, "read+write latency");
    check("chRamRead holds after write", chRamRead, 32'hA5A55A5A);
    tick(1);
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    tick(4);
    check("ram[0x40]", mem[32'h40], 32'h55);
    check("strobe queue drained", 32'(expStrobe.size()), 32'd0);
    check("done queue drained", 32'(expDone.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
